// File: rtl/pwd_pkg.sv
// Shared password-cracker constants, state encoding and charset index types.
// Reused by every cracker block that walks or decodes the 36-symbol charset.
package pwd_pkg;

   localparam int PWD_LEN      = 4;
   localparam int CHARSET_SIZE = 36;
   localparam int IDX_W        = 6;
   localparam int CHAR_W       = 8;

   typedef logic [IDX_W-1:0] idx_t;

   localparam idx_t IDX_LAST    = 6'd35;
   localparam idx_t ALPHA_COUNT = 6'd26;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pwd_candidate_gen_if.sv
// Candidate stream between a generator and its PE comparator (valid/ready).
interface pwd_candidate_gen_if #(
   parameter int PWD_LEN = 4,
   parameter int CHAR_W  = 8
);
   logic                        cand_valid;
   logic                        cand_ready;
   logic [PWD_LEN*CHAR_W-1:0]   cand;

   modport master (output cand_valid, output cand, input cand_ready);
   modport slave  (input cand_valid, input cand, output cand_ready);
endinterface

// File: rtl/pwd_char_map.sv
// Combinational charset index to ASCII: 0-25 -> 'A'-'Z', 26-35 -> '0'-'9', else '?'.
module pwd_char_map
   import pwd_pkg::*;
(
   input  idx_t              idx,
   output logic [CHAR_W-1:0] ascii
);

   // Digits start at index 26, so their base is '0' - 26 = 8'h16.
   always_comb begin
      if (idx < ALPHA_COUNT) begin
         ascii = 8'h41 + CHAR_W'(idx);
      end else if (idx <= IDX_LAST) begin
         ascii = 8'h16 + CHAR_W'(idx);
      end else begin
         ascii = 8'h3F;
      end
   end

endmodule

// File: rtl/pwd_candidate_gen.sv
// Odometer candidate generator for one PE; streams every 4-char candidate of a first-char slice.
// Optional feature macro: PWD_GEN_COUNT_EN adds a saturating accepted-handshake counter (cand_count).
module pwd_candidate_gen #(
   parameter int PWD_LEN      = pwd_pkg::PWD_LEN,
   parameter int CHARSET_SIZE = pwd_pkg::CHARSET_SIZE,
   parameter int IDX_W        = pwd_pkg::IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [IDX_W-1:0]     from,
   input  logic [IDX_W-1:0]     to,
   input  logic                 abort,
   pwd_candidate_gen_if.master  stream,
   output logic                 busy,
   output logic                 done
`ifdef PWD_GEN_COUNT_EN
   ,
   output logic [31:0]          cand_count
`endif
);
   import pwd_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARSET_SIZE - 1);

   state_t                        state_r, state_nxt;
   logic [IDX_W-1:0]              idx_r     [PWD_LEN];
   logic [IDX_W-1:0]              idx_inc_s [PWD_LEN];
   logic [IDX_W-1:0]              idx_nxt_s [PWD_LEN];
   logic [IDX_W-1:0]              to_r, to_clamp_s;
   logic [PWD_LEN*CHAR_W-1:0]     cand_r, cand_nxt_s;
   logic                          valid_r, busy_r, done_r;
   logic                          handshake_s, last_s, load_s, adv_s, start_acc_s;

   assign handshake_s = valid_r & stream.cand_ready;
   assign start_acc_s = start & (state_r != ST_RUN);

   // Clamp the requested end index into the charset.
   always_comb begin
      if (to > LAST_IDX) begin
         to_clamp_s = LAST_IDX;
      end else begin
         to_clamp_s = to;
      end
   end

   // Odometer increment (rightmost fastest) and last-candidate detect.
   always_comb begin
      logic carry;
      carry  = 1'b1;
      last_s = (idx_r[0] == to_r);
      for (int i = PWD_LEN - 1; i >= 0; i--) begin
         if (carry) begin
            if (idx_r[i] == LAST_IDX) begin
               idx_inc_s[i] = '0;
            end else begin
               idx_inc_s[i] = idx_r[i] + IDX_W'(1);
               carry        = 1'b0;
            end
         end else begin
            idx_inc_s[i] = idx_r[i];
         end
         last_s = last_s & ((i == 0) || (idx_r[i] == LAST_IDX));
      end
   end

   // Next-state logic; abort wins over a same-cycle handshake.
   always_comb begin
      state_nxt = state_r;
      load_s    = 1'b0;
      adv_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (from <= to_clamp_s) begin
                  state_nxt = ST_RUN;
                  load_s    = 1'b1;
               end else begin
                  state_nxt = ST_DONE;
               end
            end else begin
               state_nxt = state_r;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt = ST_DONE;
            end else if (handshake_s) begin
               if (last_s) begin
                  state_nxt = ST_DONE;
               end else begin
                  adv_s = 1'b1;
               end
            end else begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Next index values: load the slice start, advance, or hold.
   always_comb begin
      for (int i = 0; i < PWD_LEN; i++) begin
         if (load_s) begin
            idx_nxt_s[i] = (i == 0) ? from : '0;
         end else if (adv_s) begin
            idx_nxt_s[i] = idx_inc_s[i];
         end else begin
            idx_nxt_s[i] = idx_r[i];
         end
      end
   end

   // Map the next indices so cand can be a plain register; index 0 is the leftmost byte.
   for (genvar g = 0; g < PWD_LEN; g++) begin : g_map
      pwd_char_map u_map (
         .idx   (idx_nxt_s[g]),
         .ascii (cand_nxt_s[(PWD_LEN-1-g)*CHAR_W +: CHAR_W])
      );
   end

   // State, index and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         for (int i = 0; i < PWD_LEN; i++) begin
            idx_r[i] <= '0;
         end
         to_r    <= '0;
         cand_r  <= '0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt;
         idx_r   <= idx_nxt_s;
         if (start_acc_s) begin
            to_r <= to_clamp_s;
         end
         if (load_s || adv_s) begin
            cand_r <= cand_nxt_s;
         end
         valid_r <= (state_nxt == ST_RUN);
         busy_r  <= (state_nxt == ST_RUN);
         done_r  <= (state_nxt == ST_DONE);
      end
   end

`ifdef PWD_GEN_COUNT_EN
   logic [31:0] count_r;

   // Saturating count of accepted candidates, cleared by an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 32'd0;
      end else if (start_acc_s) begin
         count_r <= 32'd0;
      end else if (handshake_s && (count_r != 32'hFFFF_FFFF)) begin
         count_r <= count_r + 32'd1;
      end
   end

   assign cand_count = count_r;
`endif

   assign stream.cand_valid = valid_r;
   assign stream.cand       = cand_r;
   assign busy              = busy_r;
   assign done              = done_r;

endmodule

// File: tb/tb_pwd_candidate_gen.sv
// Randomized self-checking bench for pwd_candidate_gen against an ordinal-based reference model.
module tb_pwd_candidate_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  from_v;
   logic [5:0]  to_v;
   logic        abort;
   logic        busy;
   logic        done;
`ifdef PWD_GEN_COUNT_EN
   logic [31:0] cand_count;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] obs [0:199];
   logic [31:0] last_seen;

   pwd_candidate_gen_if #(.PWD_LEN(4), .CHAR_W(8)) cif ();

   pwd_candidate_gen dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .from   (from_v),
      .to     (to_v),
      .abort  (abort),
      .stream (cif),
      .busy   (busy),
      .done   (done)
`ifdef PWD_GEN_COUNT_EN
      ,
      .cand_count (cand_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sym(input int c);
      if (c < 26) return 8'(8'h41 + c);
      return 8'(8'h30 + (c - 26));
   endfunction

   // k-th candidate of a sweep starting at first character f, as a base-36 number.
   function automatic logic [31:0] exp_cand(input int f, input int k);
      int n;
      n = f * 46656 + k;
      return {sym(n / 46656), sym((n / 1296) % 36), sym((n / 36) % 36), sym(n % 36)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int f, input int t);
      from_v = 6'(f);
      to_v   = 6'(t);
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   task automatic consume(input int f, input int n_max, input int ready_pct, input int hold_at,
                          input int abort_after, input int poke_at, output int acc, output int bad);
      int   k;
      int   cyc;
      int   hold;
      logic rdy;
      logic ab;
      k = 0; cyc = 0; hold = 0; bad = 0;
      while ((k < n_max) && (cyc < n_max * 4 + 100)) begin
         if (!cif.cand_valid) break;
         if (k < 200) obs[k] = cif.cand;
         last_seen = cif.cand;
         if (cif.cand !== exp_cand(f, k)) bad++;
         if (hold > 0 && k == hold_at) begin
            check_eq("bp_hold_valid", 64'(cif.cand_valid), 64'd1);
            check_eq("bp_hold_cand", 64'(cif.cand), 64'(exp_cand(f, hold_at)));
         end
         rdy = ($urandom_range(0, 99) < ready_pct);
         if (k == hold_at && hold < 3) begin
            rdy = 1'b0;
            hold++;
         end
         ab = (k == abort_after);
         if (k == poke_at) begin
            start  = 1'b1;
            from_v = 6'd0;
            to_v   = 6'd35;
         end else begin
            start = 1'b0;
         end
         cif.cand_ready = rdy;
         abort          = ab;
         step();
         cyc++;
         if (rdy) k++;
         if (ab) break;
      end
      cif.cand_ready = 1'b0;
      abort          = 1'b0;
      start          = 1'b0;
      acc            = k;
   endtask

   initial begin
      int acc;
      int bad;
      int n_ab;
      int f;
      int t;
      int tc;
      int seen_valid;

      rst = 1'b1; start = 1'b0; from_v = 6'd0; to_v = 6'd0; abort = 1'b0; cif.cand_ready = 1'b0;
      step();
      step();
      check_eq("rst_valid", 64'(cif.cand_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_cand", 64'(cif.cand), 64'd0);
`ifdef PWD_GEN_COUNT_EN
      check_eq("rst_count", 64'(cand_count), 64'd0);
`endif
      rst = 1'b0;
      step();

      // Slice 0..0 with backpressure on "AAAC" and abort on the 100th candidate.
      do_start(0, 0);
      check_eq("s0_busy", 64'(busy), 64'd1);
      check_eq("s0_valid", 64'(cif.cand_valid), 64'd1);
      check_eq("s0_done", 64'(done), 64'd0);
      consume(0, 100, 100, 2, 99, -1, acc, bad);
      check_eq("s0_accepted", 64'(acc), 64'd100);
      check_eq("s0_model_bad", 64'(bad), 64'd0);
      check_eq("s0_first", 64'(obs[0]), 64'h4141_4141);
      check_eq("s0_bp_cand", 64'(obs[2]), 64'h4141_4143);
      check_eq("s0_after_bp", 64'(obs[3]), 64'h4141_4144);
      check_eq("s0_36th", 64'(obs[35]), 64'h4141_4139);
      check_eq("s0_37th", 64'(obs[36]), 64'h4141_4241);
      check_eq("abort_valid", 64'(cif.cand_valid), 64'd0);
      check_eq("abort_done", 64'(done), 64'd1);
      check_eq("abort_busy", 64'(busy), 64'd0);
`ifdef PWD_GEN_COUNT_EN
      check_eq("abort_count", 64'(cand_count), 64'd100);
`endif

      // Restart at "BAAA"; random ready, start poked mid-run must be ignored.
      do_start(1, 1);
      n_ab = $urandom_range(50, 150);
      consume(1, 46656, 60, -1, n_ab, 10, acc, bad);
      check_eq("s1_first", 64'(obs[0]), 64'h4241_4141);
      check_eq("s1_model_bad", 64'(bad), 64'd0);
      check_eq("s1_done", 64'(done), 64'd1);
`ifdef PWD_GEN_COUNT_EN
      check_eq("s1_count", 64'(cand_count), 64'(acc));
`endif

      abort = 1'b1;
      step();
      abort = 1'b0;
      check_eq("idle_abort_done", 64'(done), 64'd1);
      check_eq("idle_abort_valid", 64'(cif.cand_valid), 64'd0);

      // Empty range.
      do_start(5, 3);
      check_eq("empty_done", 64'(done), 64'd1);
      seen_valid = 0;
      for (int i = 0; i < 4; i++) begin
         if (cif.cand_valid) seen_valid++;
         step();
      end
      check_eq("empty_never_valid", 64'(seen_valid), 64'd0);
      check_eq("empty_done_held", 64'(done), 64'd1);

      // Asynchronous reset mid-sweep.
      do_start(2, 2);
      consume(2, 20, 100, -1, -1, -1, acc, bad);
      check_eq("s2_model_bad", 64'(bad), 64'd0);
      #3;
      rst = 1'b1;
      #1;
      check_eq("arst_valid", 64'(cif.cand_valid), 64'd0);
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_cand", 64'(cif.cand), 64'd0);
      step();
      rst = 1'b0;
      step();
      do_start(7, 8);
      check_eq("post_rst_cand", 64'(cif.cand), 64'h4841_4141);
      check_eq("post_rst_valid", 64'(cif.cand_valid), 64'd1);
`ifdef PWD_GEN_COUNT_EN
      check_eq("post_rst_count", 64'(cand_count), 64'd0);
`endif
      abort = 1'b1;
      step();
      abort = 1'b0;

      // Full clamped sweep 35..40 -> 35..35.
      do_start(35, 40);
      consume(35, 46656, 90, -1, -1, -1, acc, bad);
      check_eq("full_accepted", 64'(acc), 64'd46656);
      check_eq("full_model_bad", 64'(bad), 64'd0);
      check_eq("full_first", 64'(obs[0]), 64'h3941_4141);
      check_eq("full_last", 64'(last_seen), 64'h3939_3939);
      check_eq("full_end_valid", 64'(cif.cand_valid), 64'd0);
      check_eq("full_end_done", 64'(done), 64'd1);
      check_eq("full_end_busy", 64'(busy), 64'd0);
`ifdef PWD_GEN_COUNT_EN
      check_eq("full_count", 64'(cand_count), 64'd46656);
`endif

      // Random slices, each aborted early or empty.
      for (int it = 0; it < 6; it++) begin
         f  = $urandom_range(0, 35);
         t  = $urandom_range(0, 63);
         tc = (t > 35) ? 35 : t;
         do_start(f, t);
         if (f > tc) begin
            check_eq("rnd_empty_valid", 64'(cif.cand_valid), 64'd0);
         end else begin
            consume(f, 400, 70, -1, $urandom_range(0, 300), -1, acc, bad);
            check_eq("rnd_model_bad", 64'(bad), 64'd0);
         end
         check_eq("rnd_done", 64'(done), 64'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwd_candidate_gen.md
# pwd_candidate_gen

Upstream candidate source for one password-cracker processing element (PE). Given a first-character index range `[from, to]`, it streams every 4-character candidate over the 36-symbol charset to the PE comparator, one per cycle, using a valid/ready handshake. The cracker top instantiates one generator per PE (nine in the standard build) and gives each a disjoint `from`/`to` slice. It accepts `abort` when any PE reports a match.

## Interface
Parameters:
- `PWD_LEN`, 4: characters per candidate.
- `CHARSET_SIZE`, 36: symbols per character position.
- `IDX_W`, 6: width of one charset index.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a sweep. Sampled only in IDLE or DONE.
- `from`, in, IDX_W: first-character start index. Latched on `start`.
- `to`, in, IDX_W: first-character end index, inclusive. Latched on `start`.
- `abort`, in, 1: stop the sweep; a match was found elsewhere.
- `cand_valid`, out, 1: `cand` holds a valid candidate.
- `cand_ready`, in, 1: the comparator accepts `cand` this cycle.
- `cand`, out, PWD_LEN*8: ASCII candidate. Byte [31:24] is the leftmost character.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: the sweep finished or was aborted. Held until the next `start`.

## Operation
- **Charset map:** index 0–25 maps to 'A'–'Z' (0x41–0x5A); index 26–35 maps to '0'–'9' (0x30–0x39).
- **Counter:** PWD_LEN index registers form an odometer.
  - The rightmost character increments fastest and wraps 35→0, carrying left.
  - Character 0 runs from `from` to the latched `to`.
- **Latching `to`:** `to` > 35 is clamped to 35 when latched.
- **Sweep size:** (to−from+1)·36³ candidates.
- **States:**
  - IDLE: reset state. Outputs low.
  - RUN: streaming.
  - DONE: `done`=1, `cand_valid`=0.
- **Transitions:**
  - IDLE/DONE + `start`, with from ≤ clamped to: go to RUN. Index 0 loads `from`; the other indices load 0.
  - IDLE/DONE + `start`, with from > clamped to: go to DONE directly. No candidate is issued.
  - RUN + handshake (`cand_valid` & `cand_ready`) on the last candidate (index 0 = to, all others = 35): go to DONE.
  - RUN + `abort`: go to DONE. `abort` has priority over a same-cycle handshake. That handshake still counts as accepted by the comparator.
  - `start` in RUN is ignored. `abort` outside RUN is ignored.
- **Handshake:**
  - `cand` advances only on a handshake.
  - While `cand_valid` & !`cand_ready`, `cand` is held bit-stable.
  - `cand_valid` never drops in RUN except on the transition to DONE.
- **Reset:** asynchronous at any time, including mid-sweep. Reset values:
  - state = IDLE.
  - `cand_valid`, `busy`, `done` = 0.
  - `cand` = 32'h0.
  - All indices = 0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `start` sampled at edge N: `cand_valid`=1 with the first candidate and `busy`=1 from edge N+1.
- Throughput is one candidate per cycle while `cand_ready`=1.
- Last-candidate handshake at edge M: `cand_valid`=0, `busy`=0, `done`=1 from edge M+1.
- `abort` sampled at edge A: `cand_valid`=0 and `done`=1 from edge A+1.
- Empty range: `done`=1 from edge N+1, and `cand_valid` is never asserted.
- `done` falls at the edge after the next `start` is sampled.

## Configuration
- **`PWD_GEN_COUNT_EN` defined:**
  - Adds output port `cand_count`, 32 bits.
  - It counts accepted handshakes and clears to 0 on `start` and on reset.
  - It saturates at 32'hFFFFFFFF.
  - It holds its value in DONE for statistics readout.
- **Not defined:** the port and the counter logic are absent. All other behaviour is identical.

## Structure
- **Shared package `pwd_pkg`:**
  - Constants: `PWD_LEN`, `CHARSET_SIZE`, `IDX_W`, `CHAR_W`=8.
  - State enum: IDLE/RUN/DONE.
  - Index-range typedef.
  - The other cracker blocks reuse the same charset constants.
- **One sub-module, `pwd_char_map`:** combinational IDX_W→8-bit ASCII mapper, instantiated PWD_LEN times. Out-of-range index (>35) maps to 8'h3F ('?').

## Test plan
- from=0, to=0, `cand_ready`=1: first `cand` is "AAAA" one cycle after `start`.
  - 36th is "AAA9", 37th is "AABA".
  - 46656 handshakes, last "A999", then `done`=1 the next cycle.
  - With the macro: `cand_count`=46656.
- from=5, to=3: `done`=1 one cycle after `start`, and `cand_valid` stays 0.
- from=35, to=40: clamped. First "9AAA", last "9999", 46656 candidates.
- Backpressure: drop `cand_ready` for 3 cycles while `cand`="AAAC".
  - `cand` stays "AAAC" with `cand_valid`=1.
  - Next is "AAAD" after `cand_ready` returns.
- `abort` asserted on the 100th candidate: `cand_valid`=0 and `done`=1 next cycle. A second `start` with from=1, to=1 restarts at "BAAA".
- `rst` pulsed mid-sweep, asynchronously between edges: outputs are 0 immediately. `start` after reset begins from the new `from`.
